// File: rtl/vga_mode_sched.sv
// vga_mode_sched: selects the active test-pattern mode and sequences mode changes
// so that a new mode only takes effect on a frame boundary, followed by a run of
// black frames.
// Ports:
//   vga_clk, sys_rst_n : pixel clock, asynchronous active-low reset
//   pix_x, pix_y       : current pixel position from the timing generator
//   req_valid/req_mode : host mode-change request, handshaked with req_ready
//   btn_next           : debounced single-cycle "next mode" pulse
//   auto_en            : enables periodic auto-advance
//   mode               : pattern select for the pattern generator
//   blank              : forces black pixels downstream
//   busy               : high while a mode change is in progress
//   err                : one-cycle pulse when an out-of-range request is dropped
module vga_mode_sched #(
    parameter int unsigned H_VALID      = 640,
    parameter int unsigned V_VALID      = 480,
    parameter int unsigned NUM_MODES    = 8,
    parameter int unsigned AUTO_FRAMES  = 60,
    parameter int unsigned BLANK_FRAMES = 2
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       req_valid,
    input  logic [2:0] req_mode,
    output logic       req_ready,
    input  logic       btn_next,
    input  logic       auto_en,
    output logic [2:0] mode,
    output logic       blank,
    output logic       busy,
    output logic       err
);

    localparam int unsigned AW = (AUTO_FRAMES > 2) ? $clog2(AUTO_FRAMES) : 1;
    localparam int unsigned BW = $clog2(BLANK_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, PEND, BLANK} state_t;

    state_t        state, state_nxt;
    logic [2:0]    pend, pend_nxt;
    logic [2:0]    mode_nxt;
    logic          blank_nxt;
    logic [AW-1:0] auto_cnt, auto_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;

    logic       frame_end_c;
    logic       evt_open_c;
    logic       host_fire_c;
    logic       host_ok_c;
    logic       btn_fire_c;
    logic       auto_tick_c;
    logic [2:0] btn_tgt_c;
    logic [2:0] auto_tgt_c;

    // (v + 1) mod NUM_MODES without a divider
    function automatic logic [2:0] next_mode(input logic [2:0] v);
        return (v == 3'(NUM_MODES - 1)) ? 3'd0 : v + 3'd1;
    endfunction

    // Last active pixel of the frame
    assign frame_end_c = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

    // Events are accepted in IDLE, and in PEND except on the frame_end cycle
    assign evt_open_c  = (state == IDLE) || ((state == PEND) && !frame_end_c);
    assign req_ready   = evt_open_c;

    // Host handshake wins; an out-of-range host request still consumes the slot
    assign host_fire_c = req_valid && req_ready;
    assign host_ok_c   = host_fire_c && ({1'b0, req_mode} < 4'(NUM_MODES));
    assign btn_fire_c  = btn_next && evt_open_c && !host_fire_c;
    assign auto_tick_c = auto_en && (state == IDLE) && frame_end_c
                         && (auto_cnt == AW'(AUTO_FRAMES - 1))
                         && !host_fire_c && !btn_fire_c;

    assign btn_tgt_c  = next_mode((state == PEND) ? pend : mode);
    assign auto_tgt_c = next_mode(mode);

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        mode_nxt  = mode;
        blank_nxt = blank;
        bcnt_nxt  = bcnt;
        auto_nxt  = auto_cnt;

        case (state)
            IDLE: begin
                if (host_ok_c) begin
                    pend_nxt  = req_mode;
                    state_nxt = PEND;
                end else if (btn_fire_c) begin
                    pend_nxt  = btn_tgt_c;
                    state_nxt = PEND;
                end else if (auto_tick_c) begin
                    pend_nxt  = auto_tgt_c;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (frame_end_c) begin
                    mode_nxt  = pend;
                    blank_nxt = 1'b1;
                    state_nxt = BLANK;
                end else if (host_ok_c) begin
                    pend_nxt = req_mode;
                end else if (btn_fire_c) begin
                    pend_nxt = btn_tgt_c;
                end
            end
            BLANK: begin
                if (frame_end_c) begin
                    if (bcnt == BW'(BLANK_FRAMES - 1)) begin
                        bcnt_nxt  = '0;
                        blank_nxt = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        bcnt_nxt = bcnt + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Auto-advance frame counter, only running while idle
        if (!auto_en || host_ok_c || btn_fire_c || auto_tick_c) begin
            auto_nxt = '0;
        end else if ((state == IDLE) && frame_end_c) begin
            auto_nxt = auto_cnt + AW'(1);
        end
    end

    // State and output registers
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            mode     <= '0;
            blank    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            auto_cnt <= '0;
            bcnt     <= '0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            mode     <= mode_nxt;
            blank    <= blank_nxt;
            busy     <= (state_nxt != IDLE);
            err      <= host_fire_c && !host_ok_c;
            auto_cnt <= auto_nxt;
            bcnt     <= bcnt_nxt;
        end
    end

endmodule
